// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
//   Instruction fetch controller. Walks a word-address PC through a
//   combinational instruction memory, buffers fetched {pc, word} pairs in a
//   2-entry FIFO toward decode, halts on an all-zero instruction word and
//   restarts on a redirect. Also counts accepted instructions (saturating).
//
// Ports
//   fetch_ctrl_clk    in   clock, rising edge
//   fetch_ctrl_rst_n  in   async active-low reset
//   fetch_en          in   fetch enable from core control
//   imem_addr         out  word address to instruction memory (= PC)
//   imem_data         in   instruction word for imem_addr, same cycle
//   redirect_valid    in   branch/jump redirect request
//   redirect_addr     in   redirect target word address
//   instr_valid       out  fetch buffer head valid
//   instr_ready       in   decode accepts head
//   instr_out         out  head instruction word
//   instr_pc          out  head instruction word address
//   fetch_state       out  0 IDLE, 1 RUN, 2 HALT
//   instr_count       out  accepted-instruction count, saturating
//
// state | meaning
// IDLE  | fetch disabled; buffered words still drain to decode
// RUN   | fetching one word per edge while the buffer has room
// HALT  | zero instruction word seen; waits for a redirect
module instr_fetch_ctrl #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int RESET_PC      = 0,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     fetch_ctrl_clk,
  input  logic                     fetch_ctrl_rst_n,
  input  logic                     fetch_en,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_addr,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [31:0]              instr_out,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic [1:0]               fetch_state,
  output logic [COUNT_WIDTH-1:0]   instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] PC_RST = ADDRESS_WIDTH'(RESET_PC);
  localparam logic [ADDRESS_WIDTH-1:0] PC_ONE = ADDRESS_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]   CNT_ONE = COUNT_WIDTH'(1);

  state_t                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   pc_q, pc_d;
  logic [1:0]                 occ_q, occ_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [ADDRESS_WIDTH-1:0]   buf_pc_q   [2];
  logic [31:0]                buf_word_q [2];
  logic [COUNT_WIDTH-1:0]     count_q, count_d;

  logic accept;
  logic enq_elig;
  logic enq;
  logic halt_hit;
  logic wr_ptr;

  assign accept = instr_valid && instr_ready;

  // State register
  always_ff @(posedge fetch_ctrl_clk or negedge fetch_ctrl_rst_n) begin
    if (!fetch_ctrl_rst_n) state_q <= ST_IDLE;
    else                   state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = fetch_en ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (fetch_en) state_d = ST_RUN;
        ST_RUN: begin
          // Dropping fetch_en wins over a halt on the same edge.
          if (!fetch_en)     state_d = ST_IDLE;
          else if (halt_hit) state_d = ST_HALT;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output / fetch-strobe logic
  always_comb begin
    fetch_state = state_q;
    // A slot is free if the buffer is not full or the head leaves this edge.
    enq_elig = (state_q == ST_RUN) && fetch_en && !redirect_valid &&
               ((occ_q != 2'd2) || accept);
    enq      = enq_elig && (imem_data != 32'd0);
    halt_hit = enq_elig && (imem_data == 32'd0);
  end

  // Datapath next values
  always_comb begin
    pc_d     = pc_q;
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (accept && (count_q != {COUNT_WIDTH{1'b1}})) count_d = count_q + CNT_ONE;

    if (redirect_valid) begin
      pc_d  = redirect_addr;
      occ_d = 2'd0;
    end else begin
      if (enq) pc_d = pc_q + PC_ONE;
      if (accept) rd_ptr_d = ~rd_ptr_q;
      case ({enq, accept})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Tail slot; when full with a same-edge accept this is the slot being freed.
  assign wr_ptr = rd_ptr_q ^ occ_q[0];

  always_ff @(posedge fetch_ctrl_clk or negedge fetch_ctrl_rst_n) begin
    if (!fetch_ctrl_rst_n) begin
      pc_q          <= PC_RST;
      occ_q         <= 2'd0;
      rd_ptr_q      <= 1'b0;
      count_q       <= '0;
      buf_pc_q[0]   <= '0;
      buf_pc_q[1]   <= '0;
      buf_word_q[0] <= '0;
      buf_word_q[1] <= '0;
    end else begin
      pc_q     <= pc_d;
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (enq) begin
        buf_pc_q[wr_ptr]   <= pc_q;
        buf_word_q[wr_ptr] <= imem_data;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign instr_valid = (occ_q != 2'd0);
  // Head fields are forced to zero when nothing is buffered.
  assign instr_out   = instr_valid ? buf_word_q[rd_ptr_q] : 32'd0;
  assign instr_pc    = instr_valid ? buf_pc_q[rd_ptr_q]   : '0;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [4:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [4:0]  redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [4:0]  instr_pc;
  logic [1:0]  fetch_state;
  logic [15:0] instr_count;

  // Second instance with a 3-bit counter, driven identically.
  logic [4:0]  c3_imem_addr;
  logic        c3_instr_valid;
  logic [31:0] c3_instr_out;
  logic [4:0]  c3_instr_pc;
  logic [1:0]  c3_fetch_state;
  logic [2:0]  c3_instr_count;

  logic [31:0] mem [32];

  int vectors;
  int miscompares;

  instr_fetch_ctrl dut (
    .fetch_ctrl_clk   (clk),
    .fetch_ctrl_rst_n (rst_n),
    .fetch_en         (fetch_en),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .redirect_valid   (redirect_valid),
    .redirect_addr    (redirect_addr),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_out        (instr_out),
    .instr_pc         (instr_pc),
    .fetch_state      (fetch_state),
    .instr_count      (instr_count)
  );

  instr_fetch_ctrl #(.COUNT_WIDTH(3)) dut_c3 (
    .fetch_ctrl_clk   (clk),
    .fetch_ctrl_rst_n (rst_n),
    .fetch_en         (fetch_en),
    .imem_addr        (c3_imem_addr),
    .imem_data        (imem_data),
    .redirect_valid   (redirect_valid),
    .redirect_addr    (redirect_addr),
    .instr_valid      (c3_instr_valid),
    .instr_ready      (instr_ready),
    .instr_out        (c3_instr_out),
    .instr_pc         (c3_instr_pc),
    .fetch_state      (c3_fetch_state),
    .instr_count      (c3_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb imem_data = mem[imem_addr];

  function automatic logic [31:0] prog_word(input int a);
    return 32'h0001A003 + 32'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    for (int i = 0; i < 7; i++)  mem[i] = prog_word(i);
    mem[14] = 32'h00B18213;

    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = 5'd0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_out",   instr_out, 32'd0);
    chk("rst_pc",    32'(instr_pc), 32'd0);
    chk("rst_state", 32'(fetch_state), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_addr",  32'(imem_addr), 32'd0);
    rst_n = 1'b1;

    // Straight-line program run to HALT
    step();
    chk("run_state_e1", 32'(fetch_state), 32'd1);
    chk("run_valid_e1", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("run_valid", 32'(instr_valid), 32'd1);
      chk("run_pc",    32'(instr_pc), 32'(k));
      chk("run_word",  instr_out, prog_word(k));
    end
    step();
    chk("halt_state", 32'(fetch_state), 32'd2);
    chk("halt_addr",  32'(imem_addr), 32'd7);
    chk("halt_count", 32'(instr_count), 32'd7);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    step();
    chk("halt_held",  32'(fetch_state), 32'd2);

    // Redirect out of HALT with fetch enabled
    redirect_valid = 1'b1;
    redirect_addr  = 5'd0;
    step();
    redirect_valid = 1'b0;
    chk("redir_state", 32'(fetch_state), 32'd1);
    chk("redir_addr",  32'(imem_addr), 32'd0);
    chk("redir_valid", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("rerun_pc",   32'(instr_pc), 32'(k));
      chk("rerun_word", instr_out, prog_word(k));
    end
    step();
    chk("rehalt_state", 32'(fetch_state), 32'd2);
    chk("rehalt_count", 32'(instr_count), 32'd14);
    chk("c3_count_sat", 32'(c3_instr_count), 32'd7);

    // Redirect out of HALT with fetch disabled
    fetch_en       = 1'b0;
    redirect_valid = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("redir_idle_state", 32'(fetch_state), 32'd0);
    chk("redir_idle_addr",  32'(imem_addr), 32'd0);
    step();
    chk("idle_held", 32'(fetch_state), 32'd0);

    // Backpressure: buffer fills with pcs 0,1 and PC holds at 2
    instr_ready = 1'b0;
    fetch_en    = 1'b1;
    step();
    step();
    step();
    step();
    step();
    chk("bp_addr",  32'(imem_addr), 32'd2);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_pc",    32'(instr_pc), 32'd0);
    chk("bp_state", 32'(fetch_state), 32'd1);
    instr_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      chk("bp_drain_pc",   32'(instr_pc), 32'(k));
      chk("bp_drain_word", instr_out, prog_word(k));
    end
    instr_ready = 1'b0;
    step();
    chk("full_hold_pc",   32'(instr_pc), 32'd3);
    chk("full_hold_addr", 32'(imem_addr), 32'd5);

    // Redirect with buffer full
    redirect_valid = 1'b1;
    redirect_addr  = 5'd14;
    step();
    redirect_valid = 1'b0;
    chk("flush_valid", 32'(instr_valid), 32'd0);
    chk("flush_addr",  32'(imem_addr), 32'd14);
    chk("flush_count", 32'(instr_count), 32'd17);
    step();
    chk("tgt_valid", 32'(instr_valid), 32'd1);
    chk("tgt_pc",    32'(instr_pc), 32'd14);
    chk("tgt_word",  instr_out, 32'h00B18213);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_count", 32'(instr_count), 32'd0);
    chk("arst_state", 32'(fetch_state), 32'd0);
    chk("arst_addr",  32'(imem_addr), 32'd0);
    instr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_state", 32'(fetch_state), 32'd1);
    chk("post_rst_valid", 32'(instr_valid), 32'd0);
    step();
    chk("post_rst_pc",   32'(instr_pc), 32'd0);
    chk("post_rst_word", instr_out, prog_word(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
